// File: rtl/icache_nway.sv
// N-way set-associative instruction cache: VIPT lookup, uncached fetch, round-robin
// replacement and a hardware set walk that clears every valid bit after reset or on request.
module icache_nway #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned LINE_WORDS  = 8,
  parameter int unsigned WAYS        = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_icache_read_en,
  input  logic [ADDR_WIDTH-1:0]    virtual_addr,
  input  logic [ADDR_WIDTH-1:0]    physical_addr,
  input  logic                     uncache_en,
  input  logic                     invalidate_all_en,
  output logic                     cpu_icache_addr_request_ok,
  output logic                     icache_cpu_return_data_en,
  output logic [31:0]              icache_cpu_return_data,
  output logic                     icache_unbusy,
  output logic                     icache_mem_read_request,
  output logic [ADDR_WIDTH-1:0]    icache_mem_read_addr,
  output logic                     icache_mem_read_uncached,
  input  logic                     mem_read_addr_ok,
  input  logic                     mem_return_en,
  input  logic [LINE_WORDS*32-1:0] mem_return_data,
  output logic                     cache_hit_fail_output
);

  localparam int unsigned Sets        = 2 ** INDEX_WIDTH;
  localparam int unsigned OffsetWidth = $clog2(LINE_WORDS * 4);
  localparam int unsigned WordBits    = OffsetWidth - 2;
  localparam int unsigned WayBits     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TagWidth    = ADDR_WIDTH - INDEX_WIDTH - OffsetWidth;
  localparam int unsigned LineBits    = LINE_WORDS * 32;

  typedef enum logic [2:0] {StInval, StIdle, StLookup, StMissReq, StRefill} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] walk_q, walk_d;
  logic [ADDR_WIDTH-1:0]  pa_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [WordBits-1:0]    word_q;
  logic                   uncached_q;
  logic [WayBits-1:0]     victim_q [Sets];

  // Tag entries are {valid, tag}.
  logic [TagWidth:0]      tag_mem  [WAYS][Sets];
  logic [LineBits-1:0]    data_mem [WAYS][Sets];
  logic [TagWidth:0]      tag_rd   [WAYS];
  logic [LineBits-1:0]    data_rd  [WAYS];

  logic                   accept;
  logic                   refill_done;
  logic [INDEX_WIDTH-1:0] rd_idx, wr_idx;
  logic [WAYS-1:0]        tag_we, data_we;
  logic [TagWidth:0]      tag_wdata;
  logic [TagWidth-1:0]    pa_tag;
  logic                   hit;
  logic [LineBits-1:0]    hit_line;
  logic [WayBits-1:0]     victim, victim_next;
  logic                   unused_addr_bits;

  assign rd_idx      = virtual_addr[OffsetWidth +: INDEX_WIDTH];
  assign pa_tag      = pa_q[ADDR_WIDTH-1 -: TagWidth];
  assign victim      = victim_q[idx_q];
  assign victim_next = (victim == WayBits'(WAYS - 1)) ? '0 : victim + WayBits'(1);
  assign unused_addr_bits = ^{virtual_addr[ADDR_WIDTH-1:OffsetWidth+INDEX_WIDTH],
                              virtual_addr[1:0], pa_q[1:0]};

  // Descending scan so the lowest matching way wins.
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tag_rd[w][TagWidth] && (tag_rd[w][TagWidth-1:0] == pa_tag)) begin
        hit      = 1'b1;
        hit_line = data_rd[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (tag_we[w]) tag_mem[w][wr_idx] <= tag_wdata;
      if (data_we[w]) data_mem[w][wr_idx] <= mem_return_data;
      if (accept) begin
        tag_rd[w]  <= tag_mem[w][rd_idx];
        data_rd[w] <= data_mem[w][rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInval;
      walk_q     <= '0;
      pa_q       <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      uncached_q <= 1'b0;
      for (int s = 0; s < Sets; s++) victim_q[s] <= '0;
    end else begin
      state_q <= state_d;
      walk_q  <= walk_d;
      if (accept) begin
        pa_q       <= physical_addr;
        idx_q      <= rd_idx;
        word_q     <= virtual_addr[OffsetWidth-1:2];
        uncached_q <= uncache_en;
      end
      if (refill_done) victim_q[idx_q] <= victim_next;
    end
  end

  always_comb begin
    state_d     = state_q;
    walk_d      = walk_q;
    accept      = 1'b0;
    refill_done = 1'b0;
    tag_we      = '0;
    data_we     = '0;
    wr_idx      = idx_q;
    tag_wdata   = {1'b1, pa_tag};
    cpu_icache_addr_request_ok = 1'b0;
    icache_cpu_return_data_en  = 1'b0;
    icache_cpu_return_data     = '0;
    icache_unbusy              = 1'b0;
    icache_mem_read_request    = 1'b0;
    icache_mem_read_addr       = '0;
    icache_mem_read_uncached   = 1'b0;
    cache_hit_fail_output      = 1'b0;

    unique case (state_q)
      StInval: begin
        tag_we    = '1;
        wr_idx    = walk_q;
        tag_wdata = '0;
        walk_d    = walk_q + INDEX_WIDTH'(1);
        if (walk_q == INDEX_WIDTH'(Sets - 1)) state_d = StIdle;
      end
      StIdle: begin
        icache_unbusy = 1'b1;
        if (invalidate_all_en) begin
          state_d = StInval;
          walk_d  = '0;
        end else if (cpu_icache_read_en) begin
          accept  = 1'b1;
          cpu_icache_addr_request_ok = 1'b1;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (uncached_q) begin
          state_d = StMissReq;
        end else if (hit) begin
          icache_cpu_return_data_en = 1'b1;
          icache_cpu_return_data    = hit_line[32*word_q +: 32];
          state_d = StIdle;
        end else begin
          cache_hit_fail_output = 1'b1;
          state_d = StMissReq;
        end
      end
      StMissReq: begin
        icache_mem_read_request  = 1'b1;
        icache_mem_read_uncached = uncached_q;
        icache_mem_read_addr     = uncached_q ? {pa_q[ADDR_WIDTH-1:2], 2'b00}
                                              : {pa_q[ADDR_WIDTH-1:OffsetWidth],
                                                 {OffsetWidth{1'b0}}};
        if (mem_read_addr_ok) state_d = StRefill;
      end
      StRefill: begin
        if (mem_return_en) begin
          icache_cpu_return_data_en = 1'b1;
          if (uncached_q) begin
            icache_cpu_return_data = mem_return_data[31:0];
          end else begin
            icache_cpu_return_data = mem_return_data[32*word_q +: 32];
            refill_done = 1'b1;
            for (int w = 0; w < WAYS; w++) begin
              if (victim == WayBits'(w)) begin
                tag_we[w]  = 1'b1;
                data_we[w] = 1'b1;
              end
            end
          end
          state_d = StIdle;
        end
      end
      default: state_d = StInval;
    endcase

    // Reset aborts whatever is in flight, including a same-cycle refill.
    if (reset) begin
      accept      = 1'b0;
      refill_done = 1'b0;
      tag_we      = '0;
      data_we     = '0;
      cpu_icache_addr_request_ok = 1'b0;
      icache_cpu_return_data_en  = 1'b0;
      icache_cpu_return_data     = '0;
      icache_unbusy              = 1'b0;
      icache_mem_read_request    = 1'b0;
      icache_mem_read_addr       = '0;
      icache_mem_read_uncached   = 1'b0;
      cache_hit_fail_output      = 1'b0;
    end
  end

endmodule
